// File: rtl/signed_mult_arbiter.sv
// Round-robin arbiter that shares one 4x4 signed multiplier among NUM_REQ requesters.
// Latency: rsp_valid rises two cycles after the request handshake. A stalled rsp_ready holds the result and blocks new grants.

module bit4_signed_multiplier (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [8:0] Out
);
  logic signed [8:0] w_a_ext;
  logic signed [8:0] w_b_ext;

  assign w_a_ext = {{5{A[3]}}, A};
  assign w_b_ext = {{5{B[3]}}, B};
  assign Out     = w_a_ext * w_b_ext;
endmodule

module signed_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8:0]           rsp_data,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id_q;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic             r_rsp_valid;
  logic [8:0]       r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic [CNT_W-1:0] r_op_count;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic [8:0]       w_prod;
  logic [3:0]       w_a_arr [NUM_REQ];
  logic [3:0]       w_b_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i] = req_a[4*i +: 4];
      w_b_arr[i] = req_b[4*i +: 4];
    end
  end

  // Descending scan so the closest valid index after rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          req_ready[w_gnt] = 1'b1;
          w_state_nxt      = CALC;
        end
      end
      CALC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  bit4_signed_multiplier u_mult (
    .A   (r_op_a),
    .B   (r_op_b),
    .Out (w_prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id_q      <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_op_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_op_a   <= w_a_arr[w_gnt];
            r_op_b   <= w_b_arr[w_gnt];
            r_id_q   <= w_gnt;
            r_rr_ptr <= ID_W'((int'(w_gnt) + 1) % NUM_REQ);
          end
        end
        CALC: begin
          r_rsp_data  <= w_prod;
          r_rsp_id    <= r_id_q;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_signed_mult_arbiter.sv
// Scoreboard bench for signed_mult_arbiter: default instance plus a CNT_W=2 instance for counter wrap.
module tb_signed_mult_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] id;
    logic [8:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_valid;
  logic [4*N-1:0] req_a, req_b;
  logic [N-1:0] req_ready;
  logic         rsp_valid, rsp_ready;
  logic [8:0]   rsp_data;
  logic [1:0]   rsp_id;
  logic         busy;
  logic [15:0]  op_count;

  logic [N-1:0]   v2;
  logic [4*N-1:0] a2, b2;
  logic [N-1:0]   rdy2;
  logic           rv2, rr2;
  logic [8:0]     d2;
  logic [1:0]     id2;
  logic           busy2;
  logic [1:0]     cnt2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   obs_gnt[$];
  int   obs_gcyc[$];
  logic [8:0] obs_data[$];
  logic [1:0] obs_id[$];
  bit   timed_out;

  always #5 clk = ~clk;

  signed_mult_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy), .op_count(op_count)
  );

  signed_mult_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ready(rdy2), .rsp_valid(rv2), .rsp_ready(rr2),
    .rsp_data(d2), .rsp_id(id2), .busy(busy2), .op_count(cnt2)
  );

  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[8:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; v2 = '0; rr2 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Drives cycles until n_rsp responses complete, dropping each requester's valid after its grant.
  task automatic run_ops(input int n_rsp, input int budget);
    int pending = -1;
    int got = 0;
    obs_gnt.delete(); obs_gcyc.delete(); obs_data.delete(); obs_id.delete();
    for (int cyc = 0; cyc < budget && got < n_rsp; cyc++) begin
      if (pending >= 0) begin req_valid[pending] = 1'b0; pending = -1; end
      #1;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          obs_gnt.push_back(i); obs_gcyc.push_back(cyc); pending = i;
        end
      if (rsp_valid && rsp_ready) begin
        obs_data.push_back(rsp_data); obs_id.push_back(rsp_id); got++;
      end
      tick();
    end
    timed_out = (got < n_rsp);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    v2 = '0; rr2 = 1'b0; a2 = '0; b2 = '0;
    tick();
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_busy: got %b want 00", {rsp_valid, busy}); end
    n_checks++; if (rsp_data !== 9'h000 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_data_id: got %h/%0d want 000/0", rsp_data, rsp_id); end
    n_checks++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_t e;
    set_op(1, 4'b1010, 4'b1101);
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    exp_q.push_back({2'd1, 9'h012});
    tick();
    req_valid = '0;
    #1;
    n_checks++; if ({busy, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL single_calc: busy/valid got %b want 10", {busy, rsp_valid}); end
    tick();
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: rsp_valid got %b want 1", rsp_valid); end
    e = exp_q.pop_front();
    n_checks++; if (rsp_data !== e.data || rsp_id !== e.id) begin n_fail++; $display("FAIL single_result: got %h/%0d want %h/%0d", rsp_data, rsp_id, e.data, e.id); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_resp_ready: got %b want 0000", req_ready); end
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_count: op_count %0d valid %b want 1/0", op_count, rsp_valid); end
    tick();
  endtask

  task automatic test_all_four();
    exp_t e;
    logic [8:0] tbl [4];
    tbl = '{9'h000, 9'h1C8, 9'h1C8, 9'h040};
    do_reset();
    set_op(0, 4'h0, 4'hF); set_op(1, 4'h7, 4'h8); set_op(2, 4'h8, 4'h7); set_op(3, 4'h8, 4'h8);
    for (int i = 0; i < N; i++) exp_q.push_back({2'(i), tbl[i]});
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    run_ops(4, 40);
    rsp_ready = 1'b0;
    n_checks++; if (timed_out || obs_gnt.size() != 4) begin n_fail++; $display("FAIL all4_done: got %0d grants want 4", obs_gnt.size()); end
    for (int k = 0; k < obs_gnt.size(); k++) begin
      n_checks++; if (obs_gnt[k] != k) begin n_fail++; $display("FAIL all4_order[%0d]: got %0d want %0d", k, obs_gnt[k], k); end
      if (k > 0) begin
        n_checks++; if (obs_gcyc[k] - obs_gcyc[k-1] != 3) begin n_fail++; $display("FAIL all4_spacing[%0d]: got %0d want 3", k, obs_gcyc[k] - obs_gcyc[k-1]); end
      end
    end
    for (int k = 0; k < obs_data.size(); k++) begin
      e = exp_q.pop_front();
      n_checks++; if (obs_data[k] !== e.data || obs_id[k] !== e.id) begin n_fail++; $display("FAIL all4_rsp[%0d]: got %h/%0d want %h/%0d", k, obs_data[k], obs_id[k], e.data, e.id); end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    set_op(2, 4'h2, 4'hD);
    exp_q.push_back({2'd2, model(4'h2, 4'hD)});
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    run_ops(1, 20);
    n_checks++; if (timed_out || obs_data.size() != 1 || obs_data[0] !== exp_q[0].data) begin n_fail++; $display("FAIL rr_first: got %h want %h", obs_data.size() > 0 ? obs_data[0] : 9'h0, exp_q[0].data); end
    exp_q.delete();
    set_op(0, 4'h5, 4'h5); set_op(3, 4'h9, 4'h3);
    exp_q.push_back({2'd3, model(4'h9, 4'h3)});
    exp_q.push_back({2'd0, model(4'h5, 4'h5)});
    req_valid = 4'b1001;
    run_ops(2, 30);
    rsp_ready = 1'b0;
    n_checks++; if (timed_out || obs_gnt.size() != 2) begin n_fail++; $display("FAIL rr_done: got %0d grants want 2", obs_gnt.size()); end
    n_checks++; if (obs_gnt.size() > 0 && obs_gnt[0] != 3) begin n_fail++; $display("FAIL rr_order: first grant %0d want 3", obs_gnt[0]); end
    for (int k = 0; k < obs_data.size(); k++) begin
      e = exp_q.pop_front();
      n_checks++; if (obs_data[k] !== e.data || obs_id[k] !== e.id) begin n_fail++; $display("FAIL rr_rsp[%0d]: got %h/%0d want %h/%0d", k, obs_data[k], obs_id[k], e.data, e.id); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    do_reset();
    set_op(0, 4'h3, 4'h6); set_op(1, 4'h1, 4'h1); set_op(2, 4'h1, 4'h1); set_op(3, 4'h1, 4'h1);
    req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant: got %b want 0001", req_ready); end
    exp_q.push_back({2'd0, 9'h012});
    tick();
    req_valid[0] = 1'b0;
    tick();
    e = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b data %h id %0d ready %b want 1/%h/%0d/0000", c, rsp_valid, rsp_data, rsp_id, req_ready, e.data, e.id);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || rsp_data !== e.data) begin n_fail++; $display("FAIL bp_hs_cycle: ready %b data %h want 0000/%h", req_ready, rsp_data, e.data); end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant: got %b want 0010", req_ready); end
    n_checks++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL bp_count: got %0d want 1", op_count); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_op(2, 4'h1, 4'h1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_in_resp: rsp_valid got %b want 1", rsp_valid); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    #1;
    n_checks++; if ({rsp_valid, busy} !== 2'b00 || op_count !== 16'd0 || rsp_data !== 9'h000) begin
      n_fail++; $display("FAIL rmid_cleared: valid %b busy %b count %0d data %h want 0/0/0/000", rsp_valid, busy, op_count, rsp_data);
    end
    req_valid = 4'b1010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmid_ptr: got %b want 0010", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_counter_wrap();
    logic [1:0] seq [5];
    int n = 0;
    bit hs;
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    a2 = '0; b2 = '0;
    a2[3:0] = 4'h2; b2[3:0] = 4'h3;
    #1;
    n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL wrap_start: got %0d want 0", cnt2); end
    v2 = 4'b0001;
    rr2 = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      #1;
      hs = rv2 & rr2;
      if (hs) begin
        n_checks++; if (d2 !== 9'h006) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h want 006", n, d2); end
      end
      tick();
      if (hs) begin
        n_checks++; if (cnt2 !== seq[n]) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d want %0d", n, cnt2, seq[n]); end
        n++;
        if (n == 5) v2 = '0;
      end
    end
    rr2 = 1'b0;
    n_checks++; if (n != 5) begin n_fail++; $display("FAIL wrap_timeout: got %0d ops want 5", n); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/signed_mult_arbiter.md
Name: signed_mult_arbiter

Overview:
- Shares one bit4_signed_multiplier instance (ports A, B, Out) among NUM_REQ requesters.
- Each requester has a valid/ready request port.
- A round-robin scheduler grants one requester at a time and latches its 4-bit signed operands.
- It drives the shared multiplier and returns the 9-bit signed product, tagged with the requester ID, over a single valid/ready response port with backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester index; must equal clog2(NUM_REQ).
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  4*NUM_REQ  operand A; requester i uses bits [4i+3:4i], two's complement.
- req_b  input  4*NUM_REQ  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  9  signed product A*B, two's complement.
- rsp_id  output  ID_W  index of requester that owns rsp_data.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, op_count=0.
  - Operand latches cleared to 0.
  - Reset overrides everything, including mid-CALC/RESP; an in-flight result is discarded and no handshake is counted.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant]=1 combinationally; all other bits 0. No valid request gives req_ready=0.
  - On a handshake: latch req_a/req_b slice into op_a/op_b; latch grant into id_q; rr_ptr <= (grant+1) mod NUM_REQ; go to CALC.
- CALC (exactly 1 cycle):
  - Shared multiplier driven by op_a/op_b.
  - At end of cycle: rsp_data <= Out, rsp_id <= id_q, rsp_valid <= 1; go to RESP.
  - req_ready=0.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id held stable until handshake.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, op_count <= op_count+1, go to IDLE.
  - req_ready=0 throughout; no new request is accepted in the handshake cycle.
- Latency: request handshake in cycle N gives rsp_valid high from cycle N+2. Best-case throughput is one operation per 3 cycles.
- Multiplier operands driven only from op_a/op_b registers, never directly from request inputs.
- Arithmetic: product is the full 9-bit sign-extended result.
  - Range -56 (9'h1C8) .. +64 (9'h040); 0*x = 9'h000.
- Fairness: a requester holding valid continuously is granted within NUM_REQ grants.
- The pointer only moves on a grant; idle cycles do not advance it.
- A requester deasserting valid before its handshake is simply not granted; no state change.
- Requester inputs are ignored outside IDLE. Requesters must hold valid and operands until their req_ready handshake.
- op_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Single requester 1: a=4'b1010, b=4'b1101 (-6*-3).
  - Required: req_ready[1] high in handshake cycle; rsp_valid 2 cycles later; rsp_data=9'h012, rsp_id=1; op_count=1 after rsp handshake.
- All 4 requesters valid simultaneously after reset, rsp_ready=1.
  - Operands: (0,-1), (7,-8), (-8,7), (-8,-8).
  - Required: grants in order 0,1,2,3; rsp_data = 9'h000, 9'h1C8, 9'h1C8, 9'h040; ids 0..3; 3-cycle spacing between grants.
- Round-robin after partial progress: requester 2 served (rr_ptr=3), then requesters 0 and 3 both valid.
  - Required: requester 3 granted before 0.
- Backpressure: rsp_ready=0 for 5 cycles with requester 0 computing 3*6, other requesters valid.
  - Required: rsp_valid high and rsp_data=9'h012 stable all 5 cycles; req_ready=0 throughout; next grant only in cycle after rsp_ready=1 handshake.
- Reset mid-operation: rst_n=0 for one edge while in RESP.
  - Required: rsp_valid=0, busy=0, op_count=0, rr_ptr=0 next cycle; first subsequent grant goes to lowest valid index.
- Counter wrap: CNT_W=2, run 5 operations.
  - Required: op_count sequence 1,2,3,0,1.
